// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Time-multiplexed driver for a 4-digit common-anode seven-segment display
// with one shared segment bus. It takes the three digit patterns (hundreds,
// tens, ones) from the upstream decoder, plus a sign flag.
//
// Each frame is four slots of REFRESH_DIV cycles each, in the order ones,
// tens, hundreds, sign. Every slot opens with BLANK_CYCLES of all-anodes-off
// to suppress ghosting. All inputs are snapshotted once per frame, so a value
// that changes mid-scan never shows up mixed. Leading-zero blanking is
// optional.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   seg1       hundreds pattern, active-low {g,f,e,d,c,b,a}
//   seg2       tens pattern, same encoding
//   seg3       ones pattern, same encoding
//   sign       1 = show minus on the leftmost digit
//   blank_lz   1 = blank leading zeros (hundreds, then tens)
//   an         anode enables, active-low; an[0] = ones .. an[3] = sign
//   seg        shared segment bus, active-low
//   frame_tick one-cycle pulse at the end of each full 4-digit frame
module seg_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic [6:0] seg3,
  input  logic       sign,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_tick
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(BLANK_CYCLES);

  localparam logic [6:0] PAT_ZERO  = 7'b1000000;
  localparam logic [6:0] PAT_MINUS = 7'b0111111;
  localparam logic [6:0] PAT_OFF   = '1;

  typedef enum logic [1:0] {
    DIG_ONES  = 2'd0,
    DIG_TENS  = 2'd1,
    DIG_HUNDS = 2'd2,
    DIG_SIGN  = 2'd3
  } digit_t;

  logic [CW-1:0] cnt;
  digit_t        idx;
  logic [6:0]    sh1;
  logic [6:0]    sh2;
  logic [6:0]    sh3;
  logic          sh_sign;
  logic          sh_lz;

  logic [6:0]    dig_pat;
  logic          dig_blank;

  // Pattern and blanking for the current slot, taken from the shadows only.
  always_comb begin
    dig_pat   = PAT_OFF;
    dig_blank = 1'b0;
    unique case (idx)
      DIG_ONES: begin
        dig_pat = sh3;
      end
      DIG_TENS: begin
        dig_pat   = sh2;
        dig_blank = sh_lz && (sh1 == PAT_ZERO) && (sh2 == PAT_ZERO);
      end
      DIG_HUNDS: begin
        dig_pat   = sh1;
        dig_blank = sh_lz && (sh1 == PAT_ZERO);
      end
      DIG_SIGN: begin
        dig_pat   = PAT_MINUS;
        dig_blank = !sh_sign;
      end
      default: begin
        dig_pat   = PAT_OFF;
        dig_blank = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= DIG_ONES;
      sh1        <= '1;
      sh2        <= '1;
      sh3        <= '1;
      sh_sign    <= 1'b0;
      sh_lz      <= 1'b0;
      an         <= '1;
      seg        <= '1;
      frame_tick <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= digit_t'(idx + 2'd1);
      end else begin
        cnt <= cnt + CW'(1);
      end

      // The snapshot edge always falls inside the gap, so the outputs on this
      // edge are blank whether they see the old shadows or the new ones.
      if ((cnt == '0) && (idx == DIG_ONES)) begin
        sh1     <= seg1;
        sh2     <= seg2;
        sh3     <= seg3;
        sh_sign <= sign;
        sh_lz   <= blank_lz;
      end

      frame_tick <= (cnt == CNT_LAST) && (idx == DIG_SIGN);

      if ((cnt < GAP_END) || dig_blank) begin
        an  <= '1;
        seg <= '1;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= dig_pat;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver, run with REFRESH_DIV=8 and BLANK_CYCLES=2.
// Outputs are sampled 1 time unit after each rising edge. Sample k is the
// output registered on edge k after reset release, and the frame position
// of sample k is k mod 32.
module tb_seg_scan_driver;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg1;
  logic [6:0] seg2;
  logic [6:0] seg3;
  logic       sign;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_tick;

  int tests;
  int fails;

  localparam logic [6:0] ZERO = 7'b1000000;

  seg_scan_driver #(
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg1      (seg1),
    .seg2      (seg2),
    .seg3      (seg3),
    .sign      (sign),
    .blank_lz  (blank_lz),
    .an        (an),
    .seg       (seg),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {an, seg} at frame position k (0..31) for a given snapshot.
  function automatic logic [10:0] exp_out(input int k, input logic [6:0] s1,
                                          input logic [6:0] s2, input logic [6:0] s3,
                                          input logic sg, input logic lz);
    int slot;
    int c;
    slot = k / 8;
    c    = k % 8;
    if (c < 2) return {4'b1111, 7'b1111111};
    case (slot)
      0: return {4'b1110, s3};
      1: return (lz && s1 == ZERO && s2 == ZERO) ? {4'b1111, 7'b1111111} : {4'b1101, s2};
      2: return (lz && s1 == ZERO) ? {4'b1111, 7'b1111111} : {4'b1011, s1};
      default: return sg ? {4'b0111, 7'b0111111} : {4'b1111, 7'b1111111};
    endcase
  endfunction

  // Hold reset for one edge, apply the inputs, then release reset. Makes no
  // comparisons of its own.
  task automatic restart(input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3,
                         input logic sg, input logic lz);
    rst_n = 1'b0;
    tick();
    seg1 = s1; seg2 = s2; seg3 = s3; sign = sg; blank_lz = lz;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      seg1 = 7'($urandom); seg2 = 7'($urandom); seg3 = 7'($urandom);
      sign = 1'($urandom); blank_lz = 1'($urandom);
      tick();
      tests++;
      if ({an, seg, frame_tick} !== {4'b1111, 7'b1111111, 1'b0}) begin
        fails++;
        $display("FAIL reset cyc=%0d got an=%b seg=%b ft=%b want an=1111 seg=1111111 ft=0",
                 i, an, seg, frame_tick);
      end
    end
  endtask

  task automatic test_basic();
    logic [10:0] e;
    int          low;
    restart(7'b1111001, 7'b0100100, 7'b0110000, 1'b0, 1'b0);
    for (int k = 0; k < 64; k++) begin
      tick();
      e = exp_out(k % 32, 7'b1111001, 7'b0100100, 7'b0110000, 1'b0, 1'b0);
      tests++;
      if ({an, seg, frame_tick} !== {e, (k % 32) == 31}) begin
        fails++;
        $display("FAIL basic k=%0d got an=%b seg=%b ft=%b want an=%b seg=%b ft=%b",
                 k, an, seg, frame_tick, e[10:7], e[6:0], (k % 32) == 31);
      end
      low = 0;
      for (int b = 0; b < 4; b++) if (an[b] == 1'b0) low++;
      tests++;
      if (low > 1) begin
        fails++;
        $display("FAIL onehot k=%0d got an=%b want at most one low anode", k, an);
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [10:0] e;
    // Both upper digits zero with blanking on: only the ones anode ever lights.
    restart(ZERO, ZERO, 7'b1111000, 1'b0, 1'b1);
    for (int k = 0; k < 32; k++) begin
      tick();
      e = exp_out(k, ZERO, ZERO, 7'b1111000, 1'b0, 1'b1);
      tests++;
      if ({an, seg} !== e || (an !== 4'b1110 && an !== 4'b1111)) begin
        fails++;
        $display("FAIL lz_on k=%0d got an=%b seg=%b want an=%b seg=%b",
                 k, an, seg, e[10:7], e[6:0]);
      end
    end
    // Same digits with blanking off: the zeros are shown.
    restart(ZERO, ZERO, 7'b1111000, 1'b0, 1'b0);
    for (int k = 0; k < 32; k++) begin
      tick();
      e = exp_out(k, ZERO, ZERO, 7'b1111000, 1'b0, 1'b0);
      tests++;
      if ({an, seg} !== e) begin
        fails++;
        $display("FAIL lz_off k=%0d got an=%b seg=%b want an=%b seg=%b",
                 k, an, seg, e[10:7], e[6:0]);
      end
    end
    // Hundreds is zero but tens is not: tens stays visible.
    restart(ZERO, 7'b1111001, 7'b1111000, 1'b0, 1'b1);
    for (int k = 0; k < 32; k++) begin
      tick();
      e = exp_out(k, ZERO, 7'b1111001, 7'b1111000, 1'b0, 1'b1);
      tests++;
      if ({an, seg} !== e) begin
        fails++;
        $display("FAIL lz_tens k=%0d got an=%b seg=%b want an=%b seg=%b",
                 k, an, seg, e[10:7], e[6:0]);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [10:0] e;
    restart(7'b1111001, 7'b0100100, 7'b0110000, 1'b0, 1'b0);
    for (int k = 0; k < 64; k++) begin
      tick();
      if (k < 32) e = exp_out(k, 7'b1111001, 7'b0100100, 7'b0110000, 1'b0, 1'b0);
      else        e = exp_out(k - 32, 7'b1111001, 7'b0100100, 7'b0011001, 1'b0, 1'b0);
      tests++;
      if ({an, seg} !== e) begin
        fails++;
        $display("FAIL snapshot k=%0d got an=%b seg=%b want an=%b seg=%b",
                 k, an, seg, e[10:7], e[6:0]);
      end
      if (k == 10) seg3 = 7'b0011001;  // change lands in the tens slot
    end
  endtask

  task automatic test_sign();
    logic [10:0] e;
    restart(7'b1111001, 7'b0100100, 7'b0110000, 1'b1, 1'b0);
    for (int k = 0; k < 32; k++) begin
      tick();
      e = exp_out(k, 7'b1111001, 7'b0100100, 7'b0110000, 1'b1, 1'b0);
      tests++;
      if ({an, seg, frame_tick} !== {e, k == 31}) begin
        fails++;
        $display("FAIL sign k=%0d got an=%b seg=%b ft=%b want an=%b seg=%b ft=%b",
                 k, an, seg, frame_tick, e[10:7], e[6:0], k == 31);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] e;
    restart(7'b1111001, 7'b0100100, 7'b0110000, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) tick();
    // Sample 11 is in the tens display portion.
    tests++;
    if ({an, seg} !== {4'b1101, 7'b0100100}) begin
      fails++;
      $display("FAIL mid_pre got an=%b seg=%b want an=1101 seg=0100100", an, seg);
    end
    rst_n = 1'b0;
    seg1 = 7'b0000010; seg2 = 7'b0010010; seg3 = 7'b1111000; sign = 1'b1; blank_lz = 1'b0;
    tick();
    tests++;
    if ({an, seg, frame_tick} !== {4'b1111, 7'b1111111, 1'b0}) begin
      fails++;
      $display("FAIL mid_rst got an=%b seg=%b ft=%b want an=1111 seg=1111111 ft=0",
               an, seg, frame_tick);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      tick();
      e = exp_out(k, 7'b0000010, 7'b0010010, 7'b1111000, 1'b1, 1'b0);
      tests++;
      if ({an, seg, frame_tick} !== {e, k == 31}) begin
        fails++;
        $display("FAIL mid_resume k=%0d got an=%b seg=%b ft=%b want an=%b seg=%b ft=%b",
                 k, an, seg, frame_tick, e[10:7], e[6:0], k == 31);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    seg1 = '1; seg2 = '1; seg3 = '1; sign = 1'b0; blank_lz = 1'b0;
    test_reset();
    test_basic();
    test_leading_zero();
    test_snapshot();
    test_sign();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
